instruction_loader: RTL and testbench
=====================================

# instruction_loader

Boot-time writer for the instruction memory. Receives a byte stream from the serial receiver, assembles big-endian 32-bit instruction words and writes them sequentially from word address 0 through the memory's write port. Holds `busy` while loading; raises `done` when the declared program length has been written, so the core can be released from reset.

## Interface

Parameters:
- MEM_SIZE, 1660, instruction memory depth in words; larger programs are rejected.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  single-cycle strobe; rx_data is valid this cycle. No backpressure: every strobed byte is consumed.
- reload  in  1  single-cycle pulse; aborts any load and restarts from the header.
- we  out  1  memory write enable, one-cycle pulse per word.
- a  out  16  word address for the write.
- wd  out  32  word to write.
- busy  out  1  high from the first header byte until done or error.
- done  out  1  load completed; held until reset or reload.
- error  out  1  header length exceeded MEM_SIZE; held until reset or reload.

## Operation

- Stream format: 2-byte word count N (high byte first), then 4·N data bytes, each word most-significant byte first.
- States: LEN_HI → LEN_LO → DATA → FINISH → DONE, plus ERR.
  - LEN_HI: on rx_valid, latch N[15:8], set busy, go to LEN_LO.
  - LEN_LO: on rx_valid, latch N[7:0]. If N == 0, go to FINISH. If N > MEM_SIZE, go to ERR. Otherwise clear the word index and byte counter and go to DATA.
  - DATA: on each rx_valid, shift the byte into a 24-bit assembly register and increment a 2-bit byte counter. When the 4th byte of a word arrives:
    - register wd = {assembly[23:0], rx_data};
    - register a = word index;
    - assert we for the next cycle only;
    - increment the index.
    - If this was word N-1, go to FINISH.
  - FINISH: one cycle. Drop busy, set done, go to DONE.
  - DONE / ERR: ignore rx_valid. Only reload or reset leaves these states.
- reload, in any state: go to LEN_HI; clear busy, done, error, byte counter and index. Outputs a and wd hold their previous values.
- reload together with rx_valid in the same cycle: reload wins and the byte is discarded.
- Reset values: we=0, a=0, wd=0, busy=0, done=0, error=0; state LEN_HI; all counters 0.
- Reset asserted mid-load aborts immediately. Memory contents already written are left as they are.
- Word index is 16 bits. N ≤ MEM_SIZE, so the index never wraps.

## Timing

- Write latency: we is high in the cycle immediately after the edge that samples the 4th byte. a and wd are stable throughout that cycle.
- we is never high for two consecutive cycles, even with rx_valid asserted every cycle.
- For the last word, we and FINISH occupy the same cycle. done rises in the next cycle, so it is observed one cycle after the final we.
- ERR: error rises the cycle after the second header byte. busy falls in that same cycle. we is never asserted.
- N == 0: done rises two cycles after the second header byte, with no writes.
- rx_valid gaps of any length between bytes are allowed. Partial-word state is held across gaps.

## Test plan

- Header 00 02, data DE AD BE EF 01 23 45 67 at one byte per cycle → we pulses with (a=0, wd=DEADBEEF) and (a=1, wd=01234567); done=1 one cycle after the second pulse; busy=0.
- Same stream with random 0–10 cycle gaps between bytes → identical writes, and exactly two we pulses.
- Header 06 7D (N=1661) → error=1 and busy=0 after the second header byte; no we; further bytes ignored; a reload pulse clears error.
- Header 00 00 → done=1 with no we pulse.
- N=3, reload asserted after 5 data bytes, then a fresh stream 00 01 CA FE BA BE → single write (a=0, wd=CAFEBABE), then done.
- Reset asserted mid-DATA → all outputs 0 on the same cycle; the next stream loads from word 0.

Source files
------------

// File: rtl/instruction_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed byte stream into big-endian
// 32-bit words and writes them sequentially from word address 0.
module instruction_loader #(
  parameter int unsigned MEM_SIZE = 1660
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        reload_i,
  output logic        we_o,
  output logic [15:0] a_o,
  output logic [31:0] wd_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [15:0] MemSizeW = 16'(MEM_SIZE);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StFinish,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [15:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [15:0] len_full;
  assign len_full = {len_q[15:8], rx_data_i};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    a_d        = a_q;
    wd_d       = wd_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    // reload wins over any byte strobed in the same cycle; a/wd keep their last values
    if (reload_i) begin
      state_d    = StLenHi;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      byte_cnt_d = 2'd0;
      idx_d      = 16'd0;
    end else begin
      unique case (state_q)
        StLenHi: begin
          if (rx_valid_i) begin
            len_d[15:8] = rx_data_i;
            busy_d      = 1'b1;
            state_d     = StLenLo;
          end
        end
        StLenLo: begin
          if (rx_valid_i) begin
            len_d[7:0] = rx_data_i;
            if (len_full == 16'd0) begin
              state_d = StFinish;
            end else if (len_full > MemSizeW) begin
              state_d = StErr;
              error_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              idx_d      = 16'd0;
              byte_cnt_d = 2'd0;
              state_d    = StData;
            end
          end
        end
        StData: begin
          if (rx_valid_i) begin
            asm_d      = {asm_q[15:0], rx_data_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wd_d  = {asm_q, rx_data_i};
              a_d   = idx_q;
              we_d  = 1'b1;
              idx_d = idx_q + 16'd1;
              if (idx_q == len_q - 16'd1) begin
                state_d = StFinish;
              end
            end
          end
        end
        StFinish: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
        StDone, StErr: begin
        end
        default: state_d = StLenHi;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StLenHi;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      we_q       <= 1'b0;
      a_q        <= 16'd0;
      wd_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign we_o    = we_q;
  assign a_o     = a_q;
  assign wd_o    = wd_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus randomized streams
// compared against a word-chunking reference model.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;
  logic        we;
  logic [15:0] a;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t cap_q[$];
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  logic prev_we = 1'b0;

  instruction_loader #(.MEM_SIZE(1660)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .reload_i  (reload),
    .we_o      (we),
    .a_o       (a),
    .wd_o      (wd),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error)
  );

  always #5 clk = ~clk;

  // Write monitor: captures every we pulse and flags back-to-back pulses.
  always @(negedge clk) begin
    if (we) begin
      n_checks++;
      if (prev_we) begin
        n_fail++;
        $display("FAIL we_consecutive: we high two cycles in a row at a=%0d, required single pulse", a);
      end
      cap_q.push_back({a, wd});
    end
    prev_we = we;
  end

  // Caller must be at a negedge; byte is sampled by the next posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({we, a, wd, busy, done, error} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {we, a, wd, busy, done, error});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({we, busy, done, error} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, required 0000", {we, busy, done, error});
    end
  endtask

  task automatic test_basic();
    logic [7:0] s[10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    cap_q.delete();
    for (int i = 0; i < 10; i++) send_byte(s[i], 0);
    n_checks++;
    if (we !== 1'b1 || a !== 16'd1 || wd !== 32'h01234567 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_last_write: we=%b a=%0d wd=%h done=%b, required 1 1 01234567 0",
               we, a, wd, done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b we=%b, required 1 0 0", done, busy, we);
    end
    n_checks++;
    if (cap_q.size() != 2 || cap_q[0] !== {16'd0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL basic_writes: count=%0d first=%h, required 2 0000deadbeef",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 48'h0);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] s[10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    pulse_reload();
    cap_q.delete();
    for (int i = 0; i < 10; i++) send_byte(s[i], int'($urandom_range(0, 10)));
    repeat (3) @(negedge clk);
    n_checks++;
    if (cap_q.size() != 2) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d writes, required 2", cap_q.size());
    end else begin
      n_checks++;
      if (cap_q[0] !== {16'd0, 32'hDEADBEEF} || cap_q[1] !== {16'd1, 32'h01234567}) begin
        n_fail++;
        $display("FAIL gaps_writes: got %h %h, required 0000deadbeef 000101234567",
                 cap_q[0], cap_q[1]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_error();
    pulse_reload();
    cap_q.delete();
    send_byte(8'h06, 0);
    send_byte(8'h7D, 0);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
      n_fail++;
      $display("FAIL error_raise: error=%b busy=%b we=%b, required 1 0 0", error, busy, we);
    end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || done !== 1'b0 || cap_q.size() != 0) begin
      n_fail++;
      $display("FAIL error_hold: error=%b done=%b writes=%0d, required 1 0 0",
               error, done, cap_q.size());
    end
    pulse_reload();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: error=%b busy=%b, required 0 0", error, busy);
    end
  endtask

  task automatic test_max_len();
    pulse_reload();
    send_byte(8'h06, 0);
    send_byte(8'h7C, 0);
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL max_len_accept: error=%b busy=%b, required 0 1", error, busy);
    end
  endtask

  task automatic test_zero();
    pulse_reload();
    cap_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_finish: done=%b busy=%b, required 0 1", done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b, required 1 0", done, busy);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (cap_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_writes: got %0d writes, required 0", cap_q.size());
    end
  endtask

  task automatic test_reload();
    logic [7:0] b[5];
    logic [7:0] s[6] = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    pulse_reload();
    cap_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      send_byte(b[i], int'($urandom_range(0, 2)));
    end
    n_checks++;
    if (cap_q.size() != 1 || cap_q[0] !== {16'd0, b[0], b[1], b[2], b[3]}) begin
      n_fail++;
      $display("FAIL reload_partial: writes=%0d, required 1 with %h",
               cap_q.size(), {16'd0, b[0], b[1], b[2], b[3]});
    end
    // Byte strobed together with reload must be dropped; 0xFF as LEN_HI would force an error.
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_clear: busy=%b done=%b, required 0 0", busy, done);
    end
    cap_q.delete();
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    n_checks++;
    if (we !== 1'b1 || a !== 16'd0 || wd !== 32'hCAFEBABE) begin
      n_fail++;
      $display("FAIL reload_write: we=%b a=%0d wd=%h, required 1 0 cafebabe", we, a, wd);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || cap_q.size() != 1) begin
      n_fail++;
      $display("FAIL reload_done: done=%b error=%b writes=%0d, required 1 0 1",
               done, error, cap_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$];
    pulse_reload();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(1, 255)), 0);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({we, a, wd, busy, done, error} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0", {we, a, wd, busy, done, error});
    end
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    exp_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 8; i++) begin
      d.push_back(8'($urandom));
      send_byte(d[i], int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 2; k++) exp_q.push_back({16'(k), d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]});
    repeat (2) @(negedge clk);
    n_checks++;
    if (cap_q.size() != 2 || cap_q[0] !== exp_q[0] || cap_q[1] !== exp_q[1] || done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_reload: writes=%0d done=%b, required 2 writes from word 0 and done",
               cap_q.size(), done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      logic [7:0] d[$];
      n = int'($urandom_range(1, 7));
      pulse_reload();
      cap_q.delete();
      exp_q.delete();
      send_byte(8'(n >> 8), int'($urandom_range(0, 3)));
      send_byte(8'(n), int'($urandom_range(0, 3)));
      for (int i = 0; i < 4 * n; i++) begin
        d.push_back(8'($urandom));
        send_byte(d[i], int'($urandom_range(0, 3)));
      end
      for (int k = 0; k < n; k++) exp_q.push_back({16'(k), d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]});
      repeat (2) @(negedge clk);
      n_checks++;
      if (cap_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL random_count: iter %0d got %0d writes, required %0d",
                 it, cap_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < n; k++) begin
          n_checks++;
          if (cap_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL random_write: iter %0d word %0d got %h, required %h",
                     it, k, cap_q[k], exp_q[k]);
          end
        end
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL random_done: iter %0d done=%b busy=%b error=%b, required 1 0 0",
                 it, done, busy, error);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_error();
    test_max_len();
    test_zero();
    test_reload();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
